cp0_intc: RTL
=============

CP0_INTC -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_0001, value returned by a read of register 15.
REQ-002 SHALL have parameter HW_LINES, default 6, number of hardware interrupt inputs; fixed at 6 in this revision.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset; state is reset at a clk rising edge when reset==0.
REQ-005 SHALL have port A1, input, 5, index of the CP0 register to read.
REQ-006 SHALL have port A2, input, 5, index of the CP0 register to write.
REQ-007 SHALL have port Din, input, 32, write data (mtc0).
REQ-008 SHALL have port WE, input, 1, write enable for the register at A2.
REQ-009 SHALL have port PC, input, 30, word address [31:2] of the instruction to be interrupted.
REQ-010 SHALL have port HWInt, input, 6, level interrupt lines from peripherals (timer IRQs and others).
REQ-011 SHALL have port EXLSet, input, 1, processor accepts the interrupt this cycle.
REQ-012 SHALL have port EXLClr, input, 1, processor executes eret this cycle.
REQ-013 SHALL have port IntReq, output, 1, interrupt request to the processor.
REQ-014 SHALL have port EPC, output, 30, saved return word address.
REQ-015 SHALL have port Dout, output, 32, combinational read data for A1.

Function
REQ-016 SHALL implement SR (reg 12) with fields IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-017 SHALL implement Cause (reg 13) with field IP[15:10] and ExcCode[6:2]=0; all other bits read 0; Cause is not software-writable.
REQ-018 SHALL implement EPC (reg 14) as 30 bits, read as {EPC,2'b00}, written from Din[31:2].
REQ-019 SHALL return PRID for reg 15 and 32'h0 for every other index.
REQ-020 SHALL load IP <= HWInt on every cycle not in reset, so IP lags HWInt by exactly one cycle.
REQ-021 SHALL drive IntReq = |(HWInt & IM) & IE & ~EXL combinationally, with no added latency.
REQ-022 SHALL, on EXLSet, set EXL<=1 and EPC<=PC at the next edge.
REQ-023 SHALL, on EXLClr, clear EXL<=0 at the next edge.
REQ-024 SHALL give EXLSet priority over EXLClr when both are asserted in the same cycle.
REQ-025 SHALL give EXLSet priority over a same-cycle WE to SR.EXL or to EPC; a same-cycle WE to IM/IE still takes effect.
REQ-026 SHALL give EXLClr priority over a same-cycle WE to SR.EXL; a same-cycle WE to IM/IE still takes effect.
REQ-027 SHALL ignore WE to reg 13, reg 15 and unimplemented indices.
REQ-028 SHALL return the pre-write value when A1==A2 with WE asserted, with no write-through bypass.

Reset
REQ-029 SHALL clear SR, Cause.IP and EPC to 0 at the edge where reset==0, overriding WE, EXLSet and EXLClr.
REQ-030 SHALL hold IntReq=0 after reset until IE and an IM bit are written, because IE=0.

Structure
REQ-031 SHALL take register indices (12..15) and SR/Cause field bit positions from a shared package used by cp0 and the datapath decoder.
REQ-032 SHALL be one flat module with no sub-module; the read mux is internal.

Verification
REQ-033 Bench SHALL cover: write SR=32'h0000_FC01, then HWInt=6'b000100 -> IntReq=1 in the same cycle; Cause reads 32'h0000_1000 one cycle later.
REQ-034 Bench SHALL cover: EXLSet with PC=30'h0000_0C05 -> EPC=30'h0000_0C05, reg 14 reads 32'h0000_3014, IntReq=0 while EXL=1.
REQ-035 Bench SHALL cover: EXLSet and EXLClr in the same cycle -> EXL=1; then EXLClr alone -> EXL=0 and IntReq reasserts if HWInt is still high.
REQ-036 Bench SHALL cover: WE to A2=14 with Din=32'h1234_5678 in the same cycle as EXLSet with PC=30'h100 -> EPC=30'h100.
REQ-037 Bench SHALL cover: reset=0 during EXL=1 with pending HWInt -> SR=0, EPC=0, IntReq=0; reg 15 reads PRID; reg 20 reads 0.
REQ-038 Bench SHALL cover: IM=6'b000001 with HWInt=6'b111110 -> IntReq=0.

Source files
------------

// File: rtl/cp0_intc_pkg.sv
// Shared CP0 register map and SR/Cause field positions, used by cp0_intc and
// the datapath mtc0/mfc0 decoder so both agree on indices and bit layout.
package cp0_intc_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR.IM and Cause.IP share the same bit window
  localparam int IM_LO   = 10;
  localparam int IP_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  localparam int EPC_W = 30;

endpackage

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: SR, Cause, EPC and PRID registers, level interrupt
// request generation and EXL/EPC handling for interrupt entry and eret.
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h0000_0001,
  parameter int          HW_LINES = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         Din,
  input  logic                WE,
  input  logic [29:0]         PC,
  input  logic [HW_LINES-1:0] HWInt,
  input  logic                EXLSet,
  input  logic                EXLClr,
  output logic                IntReq,
  output logic [29:0]         EPC,
  output logic [31:0]         Dout
);

  logic [HW_LINES-1:0] im;
  logic [HW_LINES-1:0] ip;
  logic                exl;
  logic                ie;
  logic [EPC_W-1:0]    epc_q;

  logic we_sr;
  logic we_epc;

  assign we_sr  = WE && (A2 == REG_SR);
  assign we_epc = WE && (A2 == REG_EPC);

  // EXLSet beats EXLClr, and both beat software writes to EXL/EPC;
  // IM/IE writes are never blocked by interrupt entry or eret.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im    <= '0;
      ie    <= 1'b0;
      exl   <= 1'b0;
      ip    <= '0;
      epc_q <= '0;
    end else begin
      ip <= HWInt;
      if (we_sr) begin
        im <= Din[IM_LO +: HW_LINES];
        ie <= Din[IE_BIT];
      end
      if (EXLSet) begin
        exl   <= 1'b1;
        epc_q <= PC;
      end else begin
        if (EXLClr) begin
          exl <= 1'b0;
        end else if (we_sr) begin
          exl <= Din[EXL_BIT];
        end
        if (we_epc) begin
          epc_q <= Din[31:2];
        end
      end
    end
  end

  assign IntReq = (|(HWInt & im)) & ie & ~exl;
  assign EPC    = epc_q;

  always_comb begin
    Dout = 32'h0;
    case (A1)
      REG_SR: begin
        Dout[IM_LO +: HW_LINES] = im;
        Dout[EXL_BIT]           = exl;
        Dout[IE_BIT]            = ie;
      end
      REG_CAUSE: Dout[IP_LO +: HW_LINES] = ip;
      REG_EPC:   Dout = {epc_q, 2'b00};
      REG_PRID:  Dout = PRID;
      default:   Dout = 32'h0;
    endcase
  end

endmodule
